// File: rtl/mem_ctrl_be.sv
// Single-port word memory controller with byte-lane writes, configurable read latency and a post-reset clear sweep.
// Optional full-word backdoor port enabled by defining MEM_BACKDOOR_EN.
module mem_ctrl_be #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    be_i,
`ifdef MEM_BACKDOOR_EN
    input  logic                  bd_wr_i,
    input  logic [ADDR_WIDTH-1:0] bd_addr_i,
    input  logic [WIDTH-1:0]      bd_wdata_i,
    output logic [WIDTH-1:0]      bd_rdata_o,
`endif
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  ready_o,
    output logic                  err_o,
    output logic                  init_done_o
);
    localparam int                    NB        = WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            LAT_LOAD  = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [2:0]            r_lat_cnt;
    logic [WIDTH-1:0]      r_rd_q;
    logic [WIDTH-1:0]      r_rdata;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_init_done;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic w_addr_ok;
    logic w_fd_we;

    assign w_addr_ok = ({1'b0, addr_i} < DEPTH_W);
    assign w_fd_we   = (r_state == S_IDLE) && valid_i && wr_rd_i && w_addr_ok;

`ifdef MEM_BACKDOOR_EN
    logic w_bd_ok;
    assign w_bd_ok    = ({1'b0, bd_addr_i} < DEPTH_W);
    assign bd_rdata_o = w_bd_ok ? r_mem[bd_addr_i] : '0;
`endif

    // Array has no reset so it maps onto block RAM; the INIT sweep clears it instead.
    // The backdoor assignment comes last so it overrides a same-address front-door write.
    always_ff @(posedge clk_i) begin
        if (r_state == S_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else begin
            if (w_fd_we) begin
                for (int k = 0; k < NB; k++) begin
                    if (be_i[k]) begin
                        r_mem[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                    end
                end
            end
`ifdef MEM_BACKDOOR_EN
            if (bd_wr_i && w_bd_ok) begin
                r_mem[bd_addr_i] <= bd_wdata_i;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_rd_q      <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                        r_init_cnt  <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (valid_i) begin
                        if (!w_addr_ok) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else if (wr_rd_i) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                        end else if (RD_LAT == 1) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_rdata <= r_mem[addr_i];
                        end else begin
                            // Old data is captured here; later writes cannot disturb this read.
                            r_state   <= S_RD_WAIT;
                            r_rd_q    <= r_mem[addr_i];
                            r_lat_cnt <= LAT_LOAD;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat_cnt == 3'd1) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_rdata <= r_rd_q;
                    end
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign rdata_o     = r_rdata;
    assign ready_o     = r_ready;
    assign err_o       = r_err;
    assign init_done_o = r_init_done;

endmodule

// File: tb/tb_mem_ctrl_be.sv
// Bench for mem_ctrl_be: instance A (DEPTH=64, RD_LAT=1) and instance B (DEPTH=48, RD_LAT=3),
// table vectors, hand sequences and a random phase checked against an array model.
module tb_mem_ctrl_be;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_valid, a_wr, a_ready, a_err, a_done;
    logic [5:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic [1:0]  a_be;
    logic        b_valid, b_wr, b_ready, b_err, b_done;
    logic [5:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [1:0]  b_be;
`ifdef MEM_BACKDOOR_EN
    logic        a_bd_wr;
    logic [5:0]  a_bd_addr;
    logic [15:0] a_bd_wdata, a_bd_rdata, b_bd_rdata;
`endif

    mem_ctrl_be #(.WIDTH(16), .DEPTH(64), .RD_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst_n), .valid_i(a_valid), .wr_rd_i(a_wr),
        .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be),
`ifdef MEM_BACKDOOR_EN
        .bd_wr_i(a_bd_wr), .bd_addr_i(a_bd_addr), .bd_wdata_i(a_bd_wdata), .bd_rdata_o(a_bd_rdata),
`endif
        .rdata_o(a_rdata), .ready_o(a_ready), .err_o(a_err), .init_done_o(a_done)
    );

    mem_ctrl_be #(.WIDTH(16), .DEPTH(48), .RD_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst_n), .valid_i(b_valid), .wr_rd_i(b_wr),
        .addr_i(b_addr), .wdata_i(b_wdata), .be_i(b_be),
`ifdef MEM_BACKDOOR_EN
        .bd_wr_i(1'b0), .bd_addr_i(6'd0), .bd_wdata_i(16'h0000), .bd_rdata_o(b_bd_rdata),
`endif
        .rdata_o(b_rdata), .ready_o(b_ready), .err_o(b_err), .init_done_o(b_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ref_a [64];
    logic [15:0] ref_b [48];
    logic [15:0] last_rd [2];

    typedef struct {
        int          sel;
        bit          wr;
        int          addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] exp_rd;
        bit          exp_err;
        int          exp_off;
    } vec_t;
    vec_t vecs [15];

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(int sel, bit v, bit wr, logic [5:0] ad, logic [15:0] wd, logic [1:0] be);
        if (sel == 0) begin
            a_valid = v; a_wr = wr; a_addr = ad; a_wdata = wd; a_be = be;
        end else begin
            b_valid = v; b_wr = wr; b_addr = ad; b_wdata = wd; b_be = be;
        end
    endtask

    function automatic logic rdy(int sel);
        return (sel != 0) ? b_ready : a_ready;
    endfunction

    function automatic logic errf(int sel);
        return (sel != 0) ? b_err : a_err;
    endfunction

    function automatic logic [15:0] rdf(int sel);
        return (sel != 0) ? b_rdata : a_rdata;
    endfunction

    // Reference: memory is an array of words, errors for addresses beyond the depth,
    // reads answer RD_LAT edges after acceptance, writes and errors answer one edge after.
    task automatic model_access(int sel, bit wr, int addr, logic [15:0] wd, logic [1:0] be,
                                output logic [15:0] erd, output bit eerr, output int eoff);
        int depth = (sel != 0) ? 48 : 64;
        int lat   = (sel != 0) ? 3 : 1;
        logic [15:0] word;
        if (addr >= depth) begin
            eerr = 1'b1; erd = 16'h0000; eoff = 0;
        end else begin
            eerr = 1'b0;
            word = (sel != 0) ? ref_b[addr] : ref_a[addr];
            if (wr) begin
                for (int k = 0; k < 2; k++) begin
                    if (be[k]) word[k*8 +: 8] = wd[k*8 +: 8];
                end
                if (sel != 0) ref_b[addr] = word; else ref_a[addr] = word;
                erd = last_rd[sel]; eoff = 0;
            end else begin
                erd = word; eoff = lat - 1;
            end
        end
        last_rd[sel] = erd;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_a[i] = 16'h0000;
        for (int i = 0; i < 48; i++) ref_b[i] = 16'h0000;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
    endtask

    // Runs one handshake; off = edges after the acceptance edge before ready_o is seen.
    task automatic run_txn(string tag, int sel, bit wr, int addr, logic [15:0] wd, logic [1:0] be,
                           bit drop_early, logic [15:0] erd, bit eerr, int eoff);
        int off = 0;
        logic got, gone;
        logic [15:0] rd;
        logic er;
        drive(sel, 1'b1, wr, 6'(addr), wd, be);
        @(posedge clk); #1;
        if (drop_early) drive(sel, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        while (!rdy(sel) && off < 8) begin
            @(posedge clk); #1;
            off++;
        end
        got = rdy(sel);
        rd  = rdf(sel);
        er  = errf(sel);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        gone = !rdy(sel) && !errf(sel);
        $display("[TB] %s dut=%s %s addr=%0d wd=%h be=%b -> rd=%h err=%0d off=%0d",
                 tag, (sel != 0) ? "B" : "A", wr ? "WR" : "RD", addr, wd, be, rd, er, off);
        check({tag, " ready"}, 32'(got), 32'd1);
        check({tag, " rdata"}, 32'(rd), 32'(erd));
        check({tag, " err"}, 32'(er), 32'(eerr));
        check({tag, " latency"}, 32'(off), 32'(eoff));
        check({tag, " one-cycle pulse"}, 32'(gone), 32'd1);
    endtask

    // Counts edges from reset release until init_done_o rises on each instance.
    task automatic sweep(bit valid_during, output int na, output int nb, output bit seen);
        na = 0; nb = 0; seen = 1'b0;
        if (valid_during) drive(0, 1'b1, 1'b0, 6'd5, 16'h0000, 2'b00);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 10) drive(0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
            if (a_ready || b_ready) seen = 1'b1;
            if (a_done && na == 0) na = k;
            if (b_done && nb == 0) nb = k;
            if (na != 0 && nb != 0) break;
        end
    endtask

    initial begin
        int na, nb;
        bit seen;
        logic [15:0] erd;
        bit eerr;
        int eoff;

        drive(0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        drive(1, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
`ifdef MEM_BACKDOOR_EN
        a_bd_wr = 1'b0; a_bd_addr = 6'd0; a_bd_wdata = 16'h0000;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset a_ready", 32'(a_ready), 32'd0);
        check("reset a_err", 32'(a_err), 32'd0);
        check("reset a_rdata", 32'(a_rdata), 32'd0);
        check("reset a_init_done", 32'(a_done), 32'd0);
        check("reset b_init_done", 32'(b_done), 32'd0);

        // Reset mid-sweep must restart the sweep from address 0.
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid-sweep init_done", 32'(a_done), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep(1'b1, na, nb, seen);
        check("sweep length A", 32'(na), 32'd64);
        check("sweep length B", 32'(nb), 32'd48);
        check("no ready during INIT", 32'(seen), 32'd0);
        model_clear();

        vecs[0]  = '{0, 1'b0,  5, 16'h0000, 2'b00, 16'h0000, 1'b0, 0};
        vecs[1]  = '{0, 1'b1,  3, 16'hABCD, 2'b11, 16'h0000, 1'b0, 0};
        vecs[2]  = '{0, 1'b1,  3, 16'h1200, 2'b10, 16'h0000, 1'b0, 0};
        vecs[3]  = '{0, 1'b0,  3, 16'h0000, 2'b00, 16'h12CD, 1'b0, 0};
        vecs[4]  = '{1, 1'b0,  5, 16'h0000, 2'b00, 16'h0000, 1'b0, 2};
        vecs[5]  = '{1, 1'b1, 50, 16'h1234, 2'b11, 16'h0000, 1'b1, 0};
        vecs[6]  = '{1, 1'b0, 50, 16'h0000, 2'b00, 16'h0000, 1'b1, 0};
        vecs[7]  = '{1, 1'b1, 47, 16'hBEEF, 2'b01, 16'h0000, 1'b0, 0};
        vecs[8]  = '{1, 1'b0, 47, 16'h0000, 2'b00, 16'h00EF, 1'b0, 2};
        vecs[9]  = '{0, 1'b1, 63, 16'hFFFF, 2'b11, 16'h12CD, 1'b0, 0};
        vecs[10] = '{0, 1'b1, 63, 16'h0000, 2'b00, 16'h12CD, 1'b0, 0};
        vecs[11] = '{0, 1'b0, 63, 16'h0000, 2'b00, 16'hFFFF, 1'b0, 0};
        vecs[12] = '{0, 1'b1, 50, 16'h5A5A, 2'b11, 16'hFFFF, 1'b0, 0};
        vecs[13] = '{0, 1'b0, 50, 16'h0000, 2'b00, 16'h5A5A, 1'b0, 0};
        vecs[14] = '{1, 1'b0, 48, 16'h0000, 2'b00, 16'h0000, 1'b1, 0};
        for (int i = 0; i < 15; i++) begin
            model_access(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, erd, eerr, eoff);
            run_txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                    vecs[i].be, 1'b0, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_off);
        end

        // valid dropped during RD_WAIT must not abort the read.
        model_access(1, 1'b0, 47, 16'h0000, 2'b00, erd, eerr, eoff);
        run_txn("drop-early", 1, 1'b0, 47, 16'h0000, 2'b00, 1'b1, 16'h00EF, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            int sel  = int'($urandom_range(0, 1));
            bit wr   = 1'($urandom_range(0, 1));
            int addr = int'($urandom_range(0, 63));
            logic [15:0] wd = 16'($urandom);
            logic [1:0]  be = 2'($urandom_range(0, 3));
            model_access(sel, wr, addr, wd, be, erd, eerr, eoff);
            run_txn($sformatf("rnd%0d", i), sel, wr, addr, wd, be, 1'b0, erd, eerr, eoff);
        end

        // Reset during RD_WAIT: outputs clear at once, no response, sweep restarts.
        drive(1, 1'b1, 1'b0, 6'd47, 16'h0000, 2'b00);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        check("async rst b_ready", 32'(b_ready), 32'd0);
        check("async rst b_rdata", 32'(b_rdata), 32'd0);
        check("async rst b_init_done", 32'(b_done), 32'd0);
        check("async rst a_rdata", 32'(a_rdata), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (b_ready) seen = 1'b1;
        end
        rst_n = 1'b1;
        sweep(1'b0, na, nb, seen);
        check("re-sweep length B", 32'(nb), 32'd48);
        check("no ready after reset in RD_WAIT", 32'(seen), 32'd0);
        model_clear();
        run_txn("post-reset A3", 0, 1'b0, 3, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 0);
        run_txn("post-reset B47", 1, 1'b0, 47, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 2);

`ifdef MEM_BACKDOOR_EN
        a_bd_addr = 6'd7; a_bd_wdata = 16'h5555; a_bd_wr = 1'b1;
        drive(0, 1'b1, 1'b1, 6'd7, 16'hAAAA, 2'b11);
        @(posedge clk); #1;
        a_bd_wr = 1'b0;
        check("bd same-edge ready", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        check("bd_rdata after conflict", 32'(a_bd_rdata), 32'h5555);
        ref_a[7] = 16'h5555;
        run_txn("bd readback", 0, 1'b0, 7, 16'h0000, 2'b00, 1'b0, 16'h5555, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
